// File: rtl/mul_seq_unit_pkg.sv
// Shared types and constants for the sequential multiplier.
// Widths match the 32x64-bit register file it writes back into.
package mul_seq_unit_pkg;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_WB   = 2'd2
    } mul_state_t;

    localparam int XZR_IDX        = 31;
    localparam int MUL_WIDTH      = 64;
    localparam int MUL_REG_ADDR_W = 5;

endpackage

// File: rtl/mul_seq_step.sv
// Combinational shift-add step: folds BITS_PER_CYCLE partial
// products of the shifted multiplicand into the accumulator.
module mul_seq_step #(
    parameter int WIDTH          = 64,
    parameter int BITS_PER_CYCLE = 1
) (
    input  logic [2*WIDTH-1:0]        i_acc,
    input  logic [2*WIDTH-1:0]        i_mcand,
    input  logic [BITS_PER_CYCLE-1:0] i_bits,
    output logic [2*WIDTH-1:0]        o_acc
);

    always_comb begin
        o_acc = i_acc;
        for (int k = 0; k < BITS_PER_CYCLE; k++) begin
            if (i_bits[k]) begin
                o_acc = o_acc + (i_mcand << k);
            end
        end
    end

endmodule

// File: rtl/mul_seq_unit.sv
// Iterative unsigned 64x64 multiplier (MUL / UMULH) with RF writeback.
// Optional MUL_SEQ_EARLY_TERM_EN: leave RUN once the multiplier is zero.
module mul_seq_unit
    import mul_seq_unit_pkg::*;
#(
    parameter int WIDTH          = MUL_WIDTH,
    parameter int REG_ADDR_W     = MUL_REG_ADDR_W,
    parameter int BITS_PER_CYCLE = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic                  op_hi,
    input  logic [WIDTH-1:0]      a,
    input  logic [WIDTH-1:0]      b,
    input  logic [REG_ADDR_W-1:0] dest,
    input  logic                  kill,
    output logic                  busy,
    output logic                  done,
    output logic [WIDTH-1:0]      wb_data,
    output logic [REG_ADDR_W-1:0] wb_sel,
    output logic                  wb_ld
);

    localparam int N  = WIDTH / BITS_PER_CYCLE;
    localparam int CW = $clog2(N + 1);

    mul_state_t            r_state;
    logic [CW-1:0]         r_cnt;
    logic [2*WIDTH-1:0]    r_acc;
    logic [2*WIDTH-1:0]    r_mcand;
    logic [WIDTH-1:0]      r_mplier;
    logic                  r_op_hi;
    logic [REG_ADDR_W-1:0] r_dest;

    logic [2*WIDTH-1:0]    w_acc_next;
    logic [WIDTH-1:0]      w_result;
    logic                  w_last;

    mul_seq_step #(
        .WIDTH          (WIDTH),
        .BITS_PER_CYCLE (BITS_PER_CYCLE)
    ) u_step (
        .i_acc   (r_acc),
        .i_mcand (r_mcand),
        .i_bits  (r_mplier[BITS_PER_CYCLE-1:0]),
        .o_acc   (w_acc_next)
    );

`ifdef MUL_SEQ_EARLY_TERM_EN
    assign w_last = (r_mplier == '0) || (r_cnt == CW'(N - 1));
`else
    assign w_last = (r_cnt == CW'(N - 1));
`endif

    assign w_result = r_op_hi ? w_acc_next[2*WIDTH-1:WIDTH]
                              : w_acc_next[WIDTH-1:0];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state  <= S_IDLE;
            r_cnt    <= '0;
            r_acc    <= '0;
            r_mcand  <= '0;
            r_mplier <= '0;
            r_op_hi  <= 1'b0;
            r_dest   <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
            wb_ld    <= 1'b0;
            wb_data  <= '0;
            wb_sel   <= '0;
        end else begin
            done  <= 1'b0;
            wb_ld <= 1'b0;
            unique case (r_state)
                S_IDLE: begin
                    if (start && !kill) begin
                        r_mcand  <= {{WIDTH{1'b0}}, a};
                        r_mplier <= b;
                        r_op_hi  <= op_hi;
                        r_dest   <= dest;
                        r_acc    <= '0;
                        r_cnt    <= '0;
                        busy     <= 1'b1;
                        r_state  <= S_RUN;
                    end
                end
                S_RUN: begin
                    if (kill) begin
                        busy    <= 1'b0;
                        r_state <= S_IDLE;
                    end else begin
                        r_acc    <= w_acc_next;
                        r_mcand  <= r_mcand << BITS_PER_CYCLE;
                        r_mplier <= r_mplier >> BITS_PER_CYCLE;
                        r_cnt    <= r_cnt + 1'b1;
                        // Result is registered on the final RUN edge
                        if (w_last) begin
                            done    <= 1'b1;
                            wb_ld   <= (r_dest != REG_ADDR_W'(XZR_IDX));
                            wb_data <= w_result;
                            wb_sel  <= r_dest;
                            r_state <= S_WB;
                        end
                    end
                end
                S_WB: begin
                    busy    <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: begin
                    busy    <= 1'b0;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule
